// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution pass sequencer and its
// consumers (weight cache, image buffer, PE array).
//   - stage_e : 3-bit stage codes driven on o_state
//   - frame geometry and stage lengths
//   - row index and stage timer widths
package conv_pkg;

  localparam int KERNEL_SIZE    = 3;
  localparam int IMAGE_SIZE     = 8;
  localparam int ARRAY_SIZE     = 6;
  localparam int PRELOAD_CYCLES = KERNEL_SIZE * IMAGE_SIZE;
  localparam int LOAD_CYCLES    = IMAGE_SIZE;

  localparam int ROW_W   = 3;
  // PRELOAD is the longest stage, so its length sets the timer width.
  localparam int TIMER_W = $clog2(PRELOAD_CYCLES + 1);

  typedef enum logic [2:0] {
    STAGE_INIT    = 3'd0,
    STAGE_PRELOAD = 3'd1,
    STAGE_ROW_0   = 3'd2,
    STAGE_ROW_1   = 3'd3,
    STAGE_ROW_2   = 3'd4,
    STAGE_BIAS    = 3'd5,
    STAGE_LOAD    = 3'd6,
    STAGE_IDLE    = 3'd7
  } stage_e;

  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [TIMER_W-1:0] timer_t;

endpackage

// File: rtl/conv_stage_timer.sv
// conv_stage_timer: stage length down-counter.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i (stage length - 1) on stage entry
//   load_val_i  : value to load
//   zero_o      : count has reached 0 (last cycle of the stage)
module conv_stage_timer
  import conv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  timer_t load_val_i,
  output logic   zero_o
);

  timer_t cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - timer_t'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: stage sequencer for one convolution pass.
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : frame start, sampled only in INIT
//   i_abort         : cancel a frame in progress
//   o_state         : stage code (conv_pkg::stage_e)
//   o_busy          : high in every stage except INIT and IDLE
//   o_done          : one-cycle pulse while in IDLE
//   o_row_idx       : current output row
//   o_acc_clear     : first cycle of ROW_0 of each output row
//   o_result_valid  : first cycle of LOAD after BIAS (row result complete)
//
// state   | meaning
// INIT    | waiting for i_start
// PRELOAD | fill first KERNEL_SIZE image rows
// ROW_0..2| one kernel row each, KERNEL_SIZE cycles
// BIAS    | bias add, 1 cycle
// LOAD    | next image row (LOAD_CYCLES) or 1-cycle address clear at frame end / abort
// IDLE    | frame done pulse, 1 cycle
module conv_layer_ctrl
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_abort,
  output logic [2:0] o_state,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_row_idx,
  output logic       o_acc_clear,
  output logic       o_result_valid
);

  if (KERNEL_SIZE != 3) begin : g_chk_kernel
    $error("conv_layer_ctrl: KERNEL_SIZE must be 3");
  end
  if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_chk_array
    $error("conv_layer_ctrl: ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
  end
  if (ARRAY_SIZE > 8) begin : g_chk_row_w
    $error("conv_layer_ctrl: ARRAY_SIZE exceeds 3-bit row index");
  end

  stage_e state_q, state_d;
  row_t   row_q, row_d;
  logic   aborting_q, aborting_d;
  logic   busy_q, done_q, acc_clear_q, result_valid_q;

  logic   tmr_load, tmr_zero;
  timer_t tmr_val;

  logic   busy_now, abort_go, last_row;

  assign busy_now = (state_q != STAGE_INIT) && (state_q != STAGE_IDLE);
  // An abort already being flushed through LOAD is not re-armed.
  assign abort_go = i_abort && busy_now && !aborting_q;
  assign last_row = (row_q == row_t'(ARRAY_SIZE - 1));

  conv_stage_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    aborting_d = aborting_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    if (abort_go) begin
      // Abort beats any stage-end transition: one LOAD cycle clears the ROM address.
      state_d    = STAGE_LOAD;
      aborting_d = 1'b1;
      tmr_load   = 1'b1;
    end else begin
      case (state_q)
        STAGE_INIT: begin
          if (i_start) begin
            state_d  = STAGE_PRELOAD;
            row_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = timer_t'(PRELOAD_CYCLES - 1);
          end
        end
        STAGE_PRELOAD, STAGE_ROW_0, STAGE_ROW_1: begin
          if (tmr_zero) begin
            state_d  = stage_e'(state_q + 3'd1);
            tmr_load = 1'b1;
            tmr_val  = timer_t'(KERNEL_SIZE - 1);
          end
        end
        STAGE_ROW_2: begin
          if (tmr_zero) begin
            state_d  = STAGE_BIAS;
            tmr_load = 1'b1;
          end
        end
        STAGE_BIAS: begin
          state_d  = STAGE_LOAD;
          tmr_load = 1'b1;
          tmr_val  = last_row ? '0 : timer_t'(LOAD_CYCLES - 1);
        end
        STAGE_LOAD: begin
          if (tmr_zero) begin
            if (aborting_q) begin
              state_d    = STAGE_INIT;
              aborting_d = 1'b0;
              row_d      = '0;
            end else if (last_row) begin
              state_d = STAGE_IDLE;
            end else begin
              state_d  = STAGE_ROW_0;
              row_d    = row_q + row_t'(1);
              tmr_load = 1'b1;
              tmr_val  = timer_t'(KERNEL_SIZE - 1);
            end
          end
        end
        STAGE_IDLE: begin
          state_d = STAGE_INIT;
          row_d   = '0;
        end
        default: state_d = STAGE_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= STAGE_INIT;
      row_q          <= '0;
      aborting_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      acc_clear_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      aborting_q     <= aborting_d;
      busy_q         <= (state_d != STAGE_INIT) && (state_d != STAGE_IDLE);
      done_q         <= (state_d == STAGE_IDLE);
      acc_clear_q    <= (state_d == STAGE_ROW_0) && (state_q != STAGE_ROW_0);
      // Abort out of BIAS also lands in LOAD but the row result is incomplete.
      result_valid_q <= (state_d == STAGE_LOAD) && (state_q == STAGE_BIAS) && !abort_go;
    end
  end

  assign o_state        = state_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_row_idx      = row_q;
  assign o_acc_clear    = acc_clear_q;
  assign o_result_valid = result_valid_q;

endmodule
